fazyrv_ram_mp: RTL
==================

FAZYRV_RAM_MP -- requirements
Module: fazyrv_ram_mp

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- REGW, 32, word width in bits; SHALL be a multiple of 8.
- ADRW, 5, address width.
- DEPTH, 32, number of words; SHALL satisfy DEPTH <= 2**ADRW.
- NRD, 2, number of independent read ports; SHALL be >= 1.
- BYPASS, 1, same-address read/write collision policy: 1 = write-first, 0 = read-first.
- CLR_ON_RST, 1, zero the whole memory in hardware after reset (1) or skip clearing (0).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, the single clock; rising edge.
- rst_i, in, 1, reset; synchronous, active-high.
- init_done_o, out, 1, memory ready for access.
- we_i, in, 1, write enable.
- wbe_i, in, REGW/8, byte-lane write enables.
- waddr_i, in, ADRW, write address.
- wdata_i, in, REGW, write data.
- re_i, in, NRD, per-port read enable.
- raddr_i, in, NRD*ADRW, packed read addresses; port k occupies bits [k*ADRW +: ADRW].
- rdata_o, out, NRD*REGW, packed read data; port k occupies bits [k*REGW +: REGW].

Function
REQ-003 The block SHALL implement a two-state FSM, CLEAR and READY; init_done_o SHALL be 1 only in READY.
REQ-004 When rst_i is sampled high with CLR_ON_RST=1, the FSM SHALL enter CLEAR with the clear counter at 0.
REQ-005 In CLEAR, each cycle SHALL write all-zero to address counter and then increment the counter.
REQ-006 After the write to address DEPTH-1, the FSM SHALL enter READY, so init_done_o rises exactly DEPTH cycles after the first cycle with rst_i low.
REQ-007 With CLR_ON_RST=0, reset SHALL enter READY directly and memory contents SHALL be left unchanged.
REQ-008 Asserting rst_i during CLEAR SHALL restart clearing at address 0.
REQ-009 In CLEAR, we_i and re_i SHALL be ignored and rdata_o SHALL stay 0.
REQ-010 In READY, if we_i=1 and waddr_i < DEPTH, each byte lane b with wbe_i[b]=1 SHALL be written from wdata_i[8b+7:8b]; unselected lanes SHALL retain their value.
REQ-011 A write with waddr_i >= DEPTH SHALL have no effect.
REQ-012 In READY, port k with re_i[k]=1 SHALL update rdata_o port k on the next rising edge (read latency 1 cycle).
REQ-013 If re_i[k]=0, rdata_o port k SHALL hold its previous value.
REQ-014 A read with raddr >= DEPTH SHALL return 0.
REQ-015 Reads and writes SHALL be allowed in the same cycle; unlike earlier RAMs, a write SHALL NOT block reads.
REQ-016 On a same-cycle read and write to the same address with BYPASS=1, the read SHALL return the stored word merged with the enabled bytes of wdata_i.
REQ-017 On a same-cycle read and write to the same address with BYPASS=0, the read SHALL return the word as it was before the write.
REQ-018 All NRD ports SHALL be mutually independent and MAY read the same address in the same cycle.
REQ-019 The memory array SHALL have no reset other than the CLEAR sequence.

Reset
REQ-020 While rst_i is high, rdata_o SHALL be 0 and init_done_o SHALL be 0; the exception is CLR_ON_RST=0, where init_done_o SHALL be 1 from the first clock edge after rst_i is sampled high.
REQ-021 Reset SHALL have no effect between clock edges.

Verification
REQ-022 Reset/clear: DEPTH=32 with CLR_ON_RST=1, hold rst_i for 2 cycles then release -> init_done_o rises on cycle 32; a subsequent read of any address returns 0x00000000.
REQ-023 Byte-enable write: write 0xAABBCCDD to address 5 with wbe_i=1111, then write 0x11223344 to address 5 with wbe_i=0101 -> a read of address 5 returns 0xAA22CC44 one cycle after re_i.
REQ-024 Collision: write 0x12345678 to address 3 (old value 0) while port 0 reads address 3 -> rdata port 0 = 0x12345678 with BYPASS=1, and 0x00000000 with BYPASS=0.
REQ-025 Multi-port and hold: port 0 reads address 1 and port 1 reads address 2 in the same cycle -> both return correct data; with re_i then deasserted and memory rewritten, both outputs stay unchanged.
REQ-026 Reset mid-clear: assert rst_i at clear cycle 10 -> init_done_o rises exactly 32 cycles after release, and all words read 0.
REQ-027 Out of range: DEPTH=24 and ADRW=5, write to address 30 and then read address 30 -> returns 0, and words 0..23 are unchanged.

Source files
------------

// File: rtl/fazyrv_ram_mp.sv
// ---------------------------------------------------------------------------
// fazyrv_ram_mp
//
// Multi-read-port, single-write-port RAM with byte-lane write enables and an
// optional hardware clear sequence after reset.
//
// After reset (CLR_ON_RST=1) the block walks a counter over every word and
// writes zero, one word per cycle. While clearing, host writes and reads are
// ignored and all read data stays zero. Once the last word is cleared the block
// reports init_done_o and serves accesses. With CLR_ON_RST=0 the block is ready
// on the first edge after reset and memory contents are left untouched.
//
// Reads have one cycle of latency. A port whose read enable is low keeps its
// previous output. Addresses at or above DEPTH read as zero and are never
// written. A same-cycle read and write to one address returns either the
// merged new word (BYPASS=1, write-first) or the old word (BYPASS=0,
// read-first).
//
// Handshake: there is no backpressure. A write is taken on every rising edge
// where we_i=1 and the block is ready; a read on port k is taken on every rising
// edge where re_i[k]=1 and the block is ready, and its data appears on rdata_o
// port k right after that edge. init_done_o is the only "ready" indication and
// it directly reflects the FSM state (0 = CLEAR, 1 = READY).
//
// Ports:
//   clk_i       in   1           clock, rising edge
//   rst_i       in   1           synchronous active-high reset
//   init_done_o out  1           memory ready for access (FSM is READY)
//   we_i        in   1           write enable
//   wbe_i       in   REGW/8      byte-lane write enables
//   waddr_i     in   ADRW        write address
//   wdata_i     in   REGW        write data
//   re_i        in   NRD         per-port read enable
//   raddr_i     in   NRD*ADRW    packed read addresses, port k at [k*ADRW +: ADRW]
//   rdata_o     out  NRD*REGW    packed read data, port k at [k*REGW +: REGW]
// ---------------------------------------------------------------------------
module fazyrv_ram_mp #(
    parameter int REGW       = 32,
    parameter int ADRW       = 5,
    parameter int DEPTH      = 32,
    parameter int NRD        = 2,
    parameter int BYPASS     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 init_done_o,
    input  logic                 we_i,
    input  logic [REGW/8-1:0]    wbe_i,
    input  logic [ADRW-1:0]      waddr_i,
    input  logic [REGW-1:0]      wdata_i,
    input  logic [NRD-1:0]       re_i,
    input  logic [NRD*ADRW-1:0]  raddr_i,
    output logic [NRD*REGW-1:0]  rdata_o
);

    localparam int NBE = REGW / 8;

    // DEPTH may equal 2**ADRW, so comparisons use one extra address bit.
    localparam logic [ADRW:0]   DEPTH_LIM = (ADRW + 1)'(DEPTH);
    localparam logic [ADRW-1:0] LAST_ADDR = ADRW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state;
    logic [ADRW-1:0]     clr_cnt;

    logic [REGW-1:0]     mem [DEPTH];

    logic                wr_ok;
    logic [ADRW-1:0]     rd_addr [NRD];
    logic [REGW-1:0]     rd_next [NRD];

    // -----------------------------------------------------------------------
    // Clear / ready sequencing
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (CLR_ON_RST != 0) begin
                state <= CLEAR;
            end else begin
                state <= READY;
            end
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_ADDR) begin
                state <= READY;
            end
        end
    end

    // The FSM has exactly two states, so the state register is the ready flag.
    assign init_done_o = (state == READY);

    // -----------------------------------------------------------------------
    // Write port (array itself carries no reset; only the clear walk zeroes it)
    // -----------------------------------------------------------------------
    assign wr_ok = we_i && ({1'b0, waddr_i} < DEPTH_LIM);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_ok) begin
                for (int b = 0; b < NBE; b++) begin
                    if (wbe_i[b]) begin
                        mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports: next value per port, including the write-first forward
    // -----------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_addr[k] = raddr_i[k*ADRW +: ADRW];
            rd_next[k] = '0;
            if ({1'b0, rd_addr[k]} < DEPTH_LIM) begin
                rd_next[k] = mem[rd_addr[k]];
                // Overlay the bytes being written this cycle so the read sees
                // the post-write word; without it the read returns old data.
                if ((BYPASS != 0) && wr_ok && (waddr_i == rd_addr[k])) begin
                    for (int b = 0; b < NBE; b++) begin
                        if (wbe_i[b]) begin
                            rd_next[k][8*b +: 8] = wdata_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || (state == CLEAR)) begin
            rdata_o <= '0;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                if (re_i[k]) begin
                    rdata_o[k*REGW +: REGW] <= rd_next[k];
                end
            end
        end
    end

endmodule
